gate_truth_table_checker: RTL and testbench

Self-checking stimulus/response stage for the two-input gate example block. It drives the `a`/`b` operands through all four input combinations, samples the seven gate outputs after a programmable settle time, and compares them against golden logic. It reports a pass/fail summary through a start/done handshake, so the gate block can be exercised in simulation or on a board without an external bench.

---
 rtl/gate_truth_table_checker.sv | 131 +++++++++++++
 tb/tb_gate_truth_table_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_checker.sv
// Stimulus/response checker for the two-input gate block: walks a/b through all four
// combinations, compares the seven gate outputs against golden logic and reports a summary.
module gate_truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned REPEAT        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StReport} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] settle_q, settle_d;
    logic [31:0] rep_q, rep_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic        pass_q, pass_d;
    logic [6:0]  mask_q, mask_d;
    logic [7:0]  err_q, err_d;
    logic [6:0]  expected;
    logic [6:0]  diff;

    always_comb begin
        expected = {~a_q, ~(a_q ^ b_q), ~(a_q | b_q), ~(a_q & b_q), a_q ^ b_q, a_q | b_q, a_q & b_q};
        diff     = expected ^ y_in;

        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        rep_d    = rep_q;
        pass_d   = pass_q;
        mask_d   = mask_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSettle;
                    idx_d    = 2'd0;
                    settle_d = 32'd0;
                    rep_d    = 32'd0;
                    pass_d   = 1'b0;
                    mask_d   = 7'd0;
                    err_d    = 8'd0;
                end
            end
            StSettle: begin
                if (settle_q == SETTLE_CYCLES - 1) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            StSample: begin
                if (diff != 7'd0) begin
                    mask_d = mask_q | diff;
                    if (err_q != 8'hff) begin
                        err_d = err_q + 8'd1;
                    end
                end
                settle_d = 32'd0;
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StSettle;
                end else if (rep_q < REPEAT - 1) begin
                    idx_d   = 2'd0;
                    rep_d   = rep_q + 32'd1;
                    state_d = StSettle;
                end else begin
                    // Include this sample's update so pass is valid in the done cycle.
                    state_d = StReport;
                    pass_d  = (err_d == 8'd0);
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Operands follow the vector index only while a vector is in flight.
        a_d = ((state_d == StSettle) || (state_d == StSample)) && idx_d[1];
        b_d = ((state_d == StSettle) || (state_d == StSample)) && idx_d[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            settle_q <= 32'd0;
            rep_q    <= 32'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pass_q   <= 1'b0;
            mask_q   <= 7'd0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            rep_q    <= rep_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pass_q   <= pass_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StReport);
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: a gate model with injectable faults feeds two
// checker instances (default parameters and REPEAT=2/SETTLE_CYCLES=3).
module tb_gate_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       a0, b0, a1, b1;
    logic [6:0] y0, y1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [6:0] mask0, mask1;
    logic [7:0] err0, err1;
    int         fault0 = 0;
    int         fault1 = 0;
    int         sel = 0;
    int         checks = 0;
    int         errors = 0;

    logic       s_a, s_b, s_busy, s_done, s_pass;
    logic [6:0] s_mask;
    logic [7:0] s_err;

    always #5 clk = ~clk;

    // Gate model: 0 good, 1 and stuck-0, 2 not output equals a, 3 xor stuck-1.
    function automatic logic [6:0] gate_model(input logic ia, input logic ib, input int mode);
        logic [6:0] y;
        y = {~ia, ~(ia ^ ib), ~(ia | ib), ~(ia & ib), ia ^ ib, ia | ib, ia & ib};
        if (mode == 1) y[0] = 1'b0;
        if (mode == 2) y[6] = ia;
        if (mode == 3) y[2] = 1'b1;
        return y;
    endfunction

    always_comb y0 = gate_model(a0, b0, fault0);
    always_comb y1 = gate_model(a1, b1, fault1);

    always_comb begin
        if (sel == 1) begin
            s_a = a1; s_b = b1; s_busy = busy1; s_done = done1; s_pass = pass1;
            s_mask = mask1; s_err = err1;
        end else begin
            s_a = a0; s_b = b0; s_busy = busy0; s_done = done0; s_pass = pass0;
            s_mask = mask0; s_err = err0;
        end
    end

    gate_truth_table_checker dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .a         (a0),
        .b         (b0),
        .y_in      (y0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .fail_mask (mask0),
        .err_count (err0)
    );

    gate_truth_table_checker #(
        .SETTLE_CYCLES (3),
        .REPEAT        (2)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .y_in      (y1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .fail_mask (mask1),
        .err_count (err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One start pulse; walks to done checking operands at each sample cycle and final results.
    task automatic run(input int d, input int mode, input int s, input int exp_done,
                       input logic [6:0] exp_mask, input logic [7:0] exp_err,
                       input logic exp_pass);
        int cyc;
        int done_cyc;
        sel = d;
        if (d == 0) fault0 = mode; else fault1 = mode;
        @(negedge clk);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        cyc = 1;
        done_cyc = 0;
        check("busy_after_start", {31'd0, s_busy}, 32'd1);
        check("cleared_after_start", {s_pass, s_mask, s_err}, 32'd0);
        while (done_cyc == 0 && cyc < 100) begin
            if (s_done) begin
                done_cyc = cyc;
            end else begin
                if ((cyc - 1) % (s + 1) == s)
                    check("operands", {30'd0, s_a, s_b}, ((cyc - 1) / (s + 1)) % 4);
                @(negedge clk);
                cyc++;
            end
        end
        check("done_cycle", done_cyc, exp_done);
        check("pass", {31'd0, s_pass}, {31'd0, exp_pass});
        check("fail_mask", {25'd0, s_mask}, {25'd0, exp_mask});
        check("err_count", {24'd0, s_err}, {24'd0, exp_err});
        @(negedge clk);
        check("idle_after_done", {30'd0, s_busy, s_done}, 32'd0);
        check("results_held", {s_pass, s_mask, s_err}, {exp_pass, exp_mask, exp_err});
    endtask

    initial begin
        int ndone;
        int dcyc;
        int cyc;

        repeat (3) @(negedge clk);
        check("reset_dut0", {a0, b0, busy0, done0, pass0, mask0, err0}, 32'd0);
        check("reset_dut1", {a1, b1, busy1, done1, pass1, mask1, err1}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 0, 1, 9, 7'h00, 8'd0, 1'b1);
        run(0, 1, 1, 9, 7'h01, 8'd1, 1'b0);
        run(0, 2, 1, 9, 7'h40, 8'd4, 1'b0);
        run(1, 3, 3, 33, 7'h04, 8'd4, 1'b0);

        // start held high across a whole run
        sel = 0;
        fault0 = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ndone = 0;
        dcyc = 0;
        for (int c = 1; c <= 10; c++) begin
            if (done0) begin
                ndone++;
                dcyc = c;
            end
            if (c == 10) begin
                check("held_idle_gap", {31'd0, busy0}, 32'd0);
                check("held_pass_before_restart", {31'd0, pass0}, 32'd1);
            end
            @(negedge clk);
        end
        check("held_done_count", ndone, 1);
        check("held_done_cycle", dcyc, 9);
        check("held_restart_busy", {31'd0, busy0}, 32'd1);
        check("held_restart_cleared", {31'd0, pass0}, 32'd0);
        start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("held_second_run_done", {31'd0, done0}, 32'd1);
        @(negedge clk);

        // reset asserted for one cycle mid-run
        fault0 = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_err_before_reset", {24'd0, err0}, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_outputs", {a0, b0, busy0, done0, pass0, mask0, err0}, 32'd0);
        ndone = 0;
        dcyc = 0;
        for (int c = 0; c < 20; c++) begin
            if (done0) ndone++;
            if (busy0) dcyc++;
            @(negedge clk);
        end
        check("midrun_no_done", ndone, 0);
        check("midrun_stays_idle", dcyc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
